dmem_responder: RTL and testbench

- Data-memory responder for the 5-stage pipeline. It is the memory end of the M-stage interface (ALU address, store data, write enable out; load data back).
- Serves word loads combinationally within the same cycle, so the WB register captures them at the next edge. Performs stores at the clock edge.
- Decodes an MMIO window holding:
  - a free-running cycle counter;
  - a status register;
  - a TX port that pushes words into a FIFO, drained by a downstream valid/ready consumer.

---
 rtl/dmem_responder.sv | 140 ++++++++++++++
 tb/tb_dmem_responder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the M stage: word RAM with combinational loads,
// plus an MMIO window holding a cycle counter, a status register and a TX FIFO.
module dmem_responder #(
    parameter int RAM_AW     = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    output logic [31:0] rdata,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    localparam logic [15:0] OFF_TXDATA = 16'h0000;
    localparam logic [15:0] OFF_STATUS = 16'h0004;
    localparam logic [15:0] OFF_CYCLE  = 16'h0008;

    logic [31:0]       r_mem [0:(2**RAM_AW)-1];
    logic [31:0]       r_fifo [0:FIFO_DEPTH-1];
    logic [PW-1:0]     r_wrPtr;
    logic [PW-1:0]     r_rdPtr;
    logic [CW-1:0]     r_count;
    logic              r_ovf;
    logic [31:0]       r_cycle;

    logic              w_mmio;
    logic [15:0]       w_offset;
    logic [RAM_AW-1:0] w_idx;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_pushReq;
    logic              w_pushAcc;
    logic              w_statusWr;
    logic              w_cycleWr;
    logic [3:0]        w_count4;
    logic [31:0]       w_status;

    assign w_mmio     = (addr[31:16] == 16'hFFFF);
    assign w_offset   = addr[15:0];
    assign w_idx      = addr[RAM_AW+1:2];

    assign w_full     = (r_count == FULL_COUNT);
    assign w_empty    = (r_count == '0);
    assign w_pop      = out_valid && out_ready;
    assign w_pushReq  = we && w_mmio && (w_offset == OFF_TXDATA);
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_pushAcc  = w_pushReq && (!w_full || w_pop);
    assign w_statusWr = we && w_mmio && (w_offset == OFF_STATUS);
    assign w_cycleWr  = we && w_mmio && (w_offset == OFF_CYCLE);

    assign out_valid  = !w_empty;
    assign out_data   = r_fifo[r_rdPtr];

    generate
        if (CW >= 4) begin : g_countTrunc
            assign w_count4 = r_count[3:0];
        end else begin : g_countExt
            assign w_count4 = {{(4 - CW){1'b0}}, r_count};
        end
    endgenerate

    assign w_status = {24'd0, w_count4, 1'b0, r_ovf, w_empty, w_full};

    always_comb begin
        rdata = 32'd0;
        if (!w_mmio) begin
            rdata = r_mem[w_idx];
        end else begin
            case (w_offset)
                OFF_STATUS: rdata = w_status;
                OFF_CYCLE:  rdata = r_cycle;
                default:    rdata = 32'd0;
            endcase
        end
    end

    // RAM and FIFO storage are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (we && !w_mmio) begin
            r_mem[w_idx] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (w_pushAcc) begin
            r_fifo[r_wrPtr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_pushAcc) begin
                r_wrPtr <= r_wrPtr + PW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PW'(1);
            end
            case ({w_pushAcc, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Overflow is sticky until software writes STATUS.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_statusWr) begin
            r_ovf <= 1'b0;
        end else if (w_pushReq && w_full && !w_pop) begin
            r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cycle <= 32'd0;
        end else if (w_cycleWr) begin
            r_cycle <= wdata;
        end else begin
            r_cycle <= r_cycle + 32'd1;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed plan steps followed by a
// randomized phase, compared against a queue/array reference model.
module tb_dmem_responder;

    localparam int RAM_AW = 10;
    localparam int DEPTH  = 4;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;

    int compared = 0;
    int errors   = 0;

    logic [31:0] modelMem [0:(2**RAM_AW)-1];
    logic [31:0] modelQ [$];
    logic        modelOvf;
    logic [31:0] modelCycle;

    dmem_responder #(.RAM_AW(RAM_AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .wdata     (wdata),
        .we        (we),
        .rdata     (rdata),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d,
                                 input logic w, input logic r);
        addr      = a;
        wdata     = d;
        we        = w;
        out_ready = r;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] modelRdata();
        logic [31:0] r;
        r = 32'd0;
        if (addr[31:16] != 16'hFFFF) begin
            r = modelMem[addr[RAM_AW+1:2]];
        end else if (addr[15:0] == 16'h0004) begin
            r = {24'd0, 4'(modelQ.size()), 1'b0, modelOvf,
                 logic'(modelQ.size() == 0), logic'(modelQ.size() == DEPTH)};
        end else if (addr[15:0] == 16'h0008) begin
            r = modelCycle;
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag);
        chk({tag, ".rdata"}, rdata, modelRdata());
        chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, logic'(modelQ.size() != 0)});
        if (modelQ.size() != 0) begin
            chk({tag, ".data"}, out_data, modelQ[0]);
        end
    endtask

    // Advance one clock edge and update the model from the inputs held across it.
    task automatic tick();
        logic mmio;
        logic pop;
        logic push;
        mmio = (addr[31:16] == 16'hFFFF);
        pop  = (modelQ.size() != 0) && out_ready;
        push = we && mmio && (addr[15:0] == 16'h0000);
        @(posedge clk);
        if (we && !mmio) modelMem[addr[RAM_AW+1:2]] = wdata;
        if (push && modelQ.size() == DEPTH && !pop) begin
            modelOvf = 1'b1;
        end else begin
            if (pop) void'(modelQ.pop_front());
            if (push) modelQ.push_back(wdata);
        end
        if (we && mmio && addr[15:0] == 16'h0004) modelOvf = 1'b0;
        if (we && mmio && addr[15:0] == 16'h0008) modelCycle = wdata;
        else modelCycle = modelCycle + 32'd1;
        #1;
    endtask

    task automatic modelReset();
        modelQ.delete();
        modelOvf   = 1'b0;
        modelCycle = 32'd0;
    endtask

    initial begin
        logic [31:0] a;
        int          op;

        reset = 1'b1;
        applyStimulus(32'hFFFF0004, 32'd0, 1'b0, 1'b0);
        modelReset();
        #12;
        chk("rst.status", rdata, 32'h0000_0002);
        chk("rst.valid", {31'd0, out_valid}, 32'd0);
        reset = 1'b0;

        $display("[TB] preloading RAM");
        for (int i = 0; i < 2**RAM_AW; i++) begin
            applyStimulus(32'(i) << 2, $urandom, 1'b1, 1'b0);
            tick();
        end
        we = 1'b0;

        // Second reset: counter restarts, RAM is kept.
        #2 reset = 1'b1;
        modelReset();
        #1 reset = 1'b0;
        applyStimulus(32'hFFFF0008, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        chk("cycle.five", rdata, 32'd5);
        checkOutput("cycle.model");

        applyStimulus(32'hFFFF0008, 32'hFFFF_FFFE, 1'b1, 1'b0);
        tick();
        we = 1'b0;
        chk("cycle.load", rdata, 32'hFFFF_FFFE);
        tick();
        chk("cycle.max", rdata, 32'hFFFF_FFFF);
        tick();
        chk("cycle.wrap", rdata, 32'h0000_0000);

        applyStimulus(32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 1'b0);
        tick();
        we = 1'b0;
        chk("ram.load", rdata, 32'hDEAD_BEEF);
        addr = 32'h0000_0013;
        #1 chk("ram.unaligned", rdata, 32'hDEAD_BEEF);
        addr = 32'h0000_1010;
        #1 chk("ram.alias", rdata, 32'hDEAD_BEEF);

        applyStimulus(32'h0000_0010, 32'h1111_1111, 1'b1, 1'b0);
        tick();
        applyStimulus(32'h0000_0010, 32'h2222_2222, 1'b1, 1'b0);
        #1 chk("rdw.old", rdata, 32'h1111_1111);
        tick();
        we = 1'b0;
        chk("rdw.new", rdata, 32'h2222_2222);

        for (int i = 1; i <= 4; i++) begin
            applyStimulus(32'hFFFF0000, 32'(i), 1'b1, 1'b0);
            tick();
        end
        applyStimulus(32'hFFFF0004, 32'd0, 1'b0, 1'b0);
        #1 chk("fifo.full", rdata, 32'h41);
        applyStimulus(32'hFFFF0000, 32'd5, 1'b1, 1'b0);
        tick();
        applyStimulus(32'hFFFF0004, 32'd0, 1'b0, 1'b0);
        #1 chk("fifo.ovf", rdata, 32'h45);
        chk("fifo.head", out_data, 32'd1);
        applyStimulus(32'hFFFF0004, 32'd0, 1'b1, 1'b0);
        tick();
        we = 1'b0;
        #1 chk("fifo.clrovf", rdata, 32'h41);

        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("drain.data", out_data, 32'(i));
            chk("drain.valid", {31'd0, out_valid}, 32'd1);
            tick();
        end
        chk("drain.empty", {31'd0, out_valid}, 32'd0);
        chk("drain.status", rdata, 32'h02);

        for (int i = 5; i <= 8; i++) begin
            applyStimulus(32'hFFFF0000, 32'(i), 1'b1, 1'b0);
            tick();
        end
        applyStimulus(32'hFFFF0000, 32'd9, 1'b1, 1'b1);
        tick();
        applyStimulus(32'hFFFF0004, 32'd0, 1'b0, 1'b0);
        #1 chk("pushpop.status", rdata, 32'h41);
        out_ready = 1'b1;
        for (int i = 6; i <= 9; i++) begin
            chk("pushpop.data", out_data, 32'(i));
            tick();
        end
        chk("pushpop.empty", {31'd0, out_valid}, 32'd0);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(32'hFFFF0000, 32'hA0 + 32'(i), 1'b1, 1'b0);
            tick();
        end
        applyStimulus(32'hFFFF0004, 32'd0, 1'b0, 1'b0);
        #1 chk("prerst.status", rdata, 32'h30);
        #2 reset = 1'b1;
        modelReset();
        #1 chk("arst.valid", {31'd0, out_valid}, 32'd0);
        chk("arst.status", rdata, 32'h02);
        addr = 32'hFFFF0008;
        #1 chk("arst.cycle", rdata, 32'd0);
        addr = 32'h0000_0010;
        #1 chk("arst.ram", rdata, 32'h2222_2222);
        reset = 1'b0;

        $display("[TB] random phase");
        for (int n = 0; n < 400; n++) begin
            op = int'($urandom_range(0, 9));
            a  = $urandom;
            if (op <= 3) begin
                if (a[31:16] == 16'hFFFF) a[31:16] = 16'(int'($urandom_range(0, 16'hFFFE)));
                applyStimulus(a, $urandom, logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)));
            end else if (op <= 6) begin
                applyStimulus(32'hFFFF0000, $urandom, logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)));
            end else if (op == 7) begin
                applyStimulus(32'hFFFF0004, $urandom, logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 1)));
            end else if (op == 8) begin
                applyStimulus(32'hFFFF0008, $urandom, logic'($urandom_range(0, 7) == 0), logic'($urandom_range(0, 1)));
            end else begin
                applyStimulus({16'hFFFF, a[15:0]}, $urandom, logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)));
            end
            #1 checkOutput("rand");
            tick();
        end
        we = 1'b0;
        #1 checkOutput("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errors);
        $finish;
    end

endmodule
